// File: rtl/switch_allocator_if.sv
// Allocator bus: per-input request/FIFO-head information in, per-output
// ownership, crossbar selects and transfer strobes out.
interface switch_allocator_if #(
  parameter int NPORT = 5
);
  logic [NPORT*NPORT-1:0] req;
  logic [NPORT-1:0]       valid;
  logic [3*NPORT-1:0]     flit_id;
  logic [NPORT-1:0]       out_ready;
  logic [NPORT*NPORT-1:0] grant;
  logic [3*NPORT-1:0]     xbar_sel;
  logic [NPORT-1:0]       rd_en;
  logic [NPORT-1:0]       out_valid;

  modport master (
    output req, valid, flit_id, out_ready,
    input  grant, xbar_sel, rd_en, out_valid
  );

  modport slave (
    input  req, valid, flit_id, out_ready,
    output grant, xbar_sel, rd_en, out_valid
  );
endinterface

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: one IDLE/BUSY FSM per output with round-robin
// arbitration among inputs presenting a HEADER flit; ownership ends on TAIL.
module switch_allocator #(
  parameter int         NPORT = 5,
  parameter logic [2:0] HDR   = 3'b001,
  parameter logic [2:0] BODY  = 3'b010,
  parameter logic [2:0] TAIL  = 3'b100
) (
  input logic               clk,
  input logic               rst,
  switch_allocator_if.slave sa
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  localparam logic [2:0] NONE = 3'd7;

  if (HDR == BODY || HDR == TAIL || BODY == TAIL) begin : g_bad_codes
    $error("switch_allocator: flit_id codes must be distinct");
  end

  state_t                 state_q [NPORT];
  state_t                 state_d [NPORT];
  logic [2:0]             owner_q [NPORT];
  logic [2:0]             owner_d [NPORT];
  logic [2:0]             ptr_q   [NPORT];
  logic [2:0]             ptr_d   [NPORT];
  logic [NPORT*NPORT-1:0] grant_q, grant_d;
  logic [3*NPORT-1:0]     xbar_q, xbar_d;

  logic [NPORT-1:0]       low   [NPORT];
  logic [NPORT-1:0]       cand  [NPORT];
  logic [NPORT-1:0]       owned;
  logic [NPORT-1:0]       taken;
  logic [NPORT-1:0]       rd_en_c, out_valid_c;

  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    return (int'(v) + 1 >= NPORT) ? 3'd0 : v + 3'd1;
  endfunction

  // An input may claim only the lowest output in its route, and only when
  // it is not already streaming a packet through some output.
  always_comb begin
    owned = '0;
    for (int i = 0; i < NPORT; i++) begin
      low[i] = sa.req[i*NPORT +: NPORT] & (~sa.req[i*NPORT +: NPORT] + NPORT'(1));
      for (int o = 0; o < NPORT; o++)
        if (state_q[o] == BUSY && owner_q[o] == 3'(i)) owned[i] = 1'b1;
    end
    for (int o = 0; o < NPORT; o++) begin
      cand[o] = '0;
      for (int i = 0; i < NPORT; i++)
        cand[o][i] = sa.valid[i] && (sa.flit_id[i*3 +: 3] == HDR) && !owned[i] && low[i][o];
    end
  end

  always_comb begin
    int         idx;
    logic       found;
    logic [2:0] pick;
    idx         = 0;
    found       = 1'b0;
    pick        = 3'd0;
    taken       = '0;
    rd_en_c     = '0;
    out_valid_c = '0;
    for (int o = 0; o < NPORT; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      if (state_q[o] == BUSY) begin
        for (int i = 0; i < NPORT; i++) begin
          if (owner_q[o] == 3'(i) && sa.valid[i] && sa.out_ready[o]) begin
            out_valid_c[o] = 1'b1;
            rd_en_c[i]     = 1'b1;
            if (sa.flit_id[i*3 +: 3] == TAIL) begin
              state_d[o] = IDLE;
              ptr_d[o]   = wrap_inc(owner_q[o]);
            end
          end
        end
      end else begin
        found = 1'b0;
        pick  = 3'd0;
        for (int k = 0; k < NPORT; k++) begin
          idx = int'(ptr_q[o]) + k;
          if (idx >= NPORT) idx = idx - NPORT;
          if (!found && cand[o][idx]) begin
            found = 1'b1;
            pick  = 3'(idx);
          end
        end
        // A lower output already took this input: stay idle this cycle.
        if (found && !taken[pick]) begin
          taken[pick] = 1'b1;
          state_d[o]  = BUSY;
          owner_d[o]  = pick;
        end
      end
    end
    if (rst) begin
      rd_en_c     = '0;
      out_valid_c = '0;
    end
  end

  always_comb begin
    grant_d = '0;
    xbar_d  = {NPORT{NONE}};
    for (int o = 0; o < NPORT; o++) begin
      if (state_d[o] == BUSY) begin
        xbar_d[o*3 +: 3] = owner_d[o];
        for (int i = 0; i < NPORT; i++)
          if (owner_d[o] == 3'(i)) grant_d[o*NPORT + i] = 1'b1;
      end
    end
  end

  // ---- allocation register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NPORT; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= 3'd0;
        ptr_q[o]   <= 3'd0;
      end
      grant_q <= '0;
      xbar_q  <= {NPORT{NONE}};
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
      grant_q <= grant_d;
      xbar_q  <= xbar_d;
    end
  end

  assign sa.grant     = grant_q;
  assign sa.xbar_sel  = xbar_q;
  assign sa.rd_en     = rd_en_c;
  assign sa.out_valid = out_valid_c;
endmodule

// File: tb/tb_switch_allocator.sv
// Table-driven check of switch_allocator with a scoreboard queue, plus a
// fairness sequence with a small FIFO-head model for four competing inputs.
module tb_switch_allocator;
  localparam int N = 5;
  localparam logic [2:0] H = 3'b001, B = 3'b010, T = 3'b100, Z = 3'b000, I = 3'd7;
  localparam logic [4:0] O = 5'b00000, NN = 5'b00001, E = 5'b00010;
  localparam logic [4:0] S = 5'b01000, L = 5'b10000, ALL = 5'b11111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  switch_allocator_if #(.NPORT(N)) sif ();
  switch_allocator #(.NPORT(N), .HDR(H), .BODY(B), .TAIL(T)) dut (
    .clk (clk),
    .rst (rst),
    .sa  (sif)
  );

  typedef struct {
    logic        rs;
    logic [24:0] req;
    logic [4:0]  valid;
    logic [14:0] fid;
    logic [4:0]  ordy;
    logic [4:0]  rd;
    logic [4:0]  ov;
    logic [14:0] own;
  } vec_t;

  typedef struct {
    int          tag;
    logic [4:0]  rd;
    logic [4:0]  ov;
    logic [24:0] grant;
    logic [14:0] xbar;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   ownq[$];
  int   total = 0;
  int   bad   = 0;

  logic [14:0] IDL;
  logic [2:0]  head [4];
  logic [4:0]  rdv;
  int          cyc, got, want;

  function automatic logic [24:0] r5(input logic [4:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  function automatic logic [14:0] f5(input logic [2:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  function automatic logic [24:0] g_of(input logic [14:0] own);
    logic [24:0] g;
    logic [2:0]  v;
    g = '0;
    for (int o = 0; o < N; o++) begin
      v = own[o*3 +: 3];
      if (v != 3'd7) g[o*N + int'(v)] = 1'b1;
    end
    return g;
  endfunction

  function automatic void row(input logic rs, input logic [24:0] rq, input logic [4:0] vl,
                              input logic [14:0] fd, input logic [4:0] rdy,
                              input logic [4:0] rd, input logic [4:0] ov, input logic [14:0] own);
    vec_t v;
    v.rs = rs; v.req = rq; v.valid = vl; v.fid = fd; v.ordy = rdy;
    v.rd = rd; v.ov = ov; v.own = own;
    tbl.push_back(v);
  endfunction

  task automatic cmp(input string nm, input int tag, input logic [24:0] act, input logic [24:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h expected %h", nm, tag, act, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic [24:0] rq, input logic [4:0] vl,
                       input logic [14:0] fd, input logic [4:0] rdy);
    rst           = rs;
    sif.req       = rq;
    sif.valid     = vl;
    sif.flit_id   = fd;
    sif.out_ready = rdy;
  endtask

  task automatic apply(input vec_t v, input int tag);
    exp_t e;
    drive(v.rs, v.req, v.valid, v.fid, v.ordy);
    e.tag = tag; e.rd = v.rd; e.ov = v.ov; e.grant = g_of(v.own); e.xbar = v.own;
    sbq.push_back(e);
    @(negedge clk);
    if (sbq.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard row %0d: queue empty", tag);
    end else begin
      e = sbq.pop_front();
      cmp("rd_en",     e.tag, 25'(sif.rd_en),     25'(e.rd));
      cmp("out_valid", e.tag, 25'(sif.out_valid), 25'(e.ov));
      cmp("grant",     e.tag, sif.grant,          e.grant);
      cmp("xbar_sel",  e.tag, 25'(sif.xbar_sel),  25'(e.xbar));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    IDL = f5(I, I, I, I, I);
    drive(1'b1, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;

    // Single packet 0 -> E, including a reset cycle with live inputs
    row(1, r5(E,O,O,O,O), 5'b00001, f5(H,Z,Z,Z,Z), ALL, O, O, IDL);
    row(0, r5(E,O,O,O,O), 5'b00001, f5(H,Z,Z,Z,Z), ALL, O, O, IDL);
    row(0, r5(E,O,O,O,O), 5'b00001, f5(H,Z,Z,Z,Z), ALL, 5'b00001, E, f5(I,0,I,I,I));
    row(0, r5(E,O,O,O,O), 5'b00001, f5(B,Z,Z,Z,Z), ALL, 5'b00001, E, f5(I,0,I,I,I));
    row(0, r5(E,O,O,O,O), 5'b00001, f5(T,Z,Z,Z,Z), ALL, 5'b00001, E, f5(I,0,I,I,I));
    row(0, '0, O, '0, ALL, O, O, IDL);
    // Contention on L between inputs 1 and 3; pointer moves past the winner
    row(0, r5(O,L,O,L,O), 5'b01010, f5(Z,H,Z,H,Z), ALL, O, O, IDL);
    row(0, r5(O,L,O,L,O), 5'b01010, f5(Z,H,Z,H,Z), ALL, 5'b00010, L, f5(I,I,I,I,1));
    row(0, r5(O,L,O,L,O), 5'b01010, f5(Z,T,Z,H,Z), ALL, 5'b00010, L, f5(I,I,I,I,1));
    row(0, r5(O,L,O,L,O), 5'b01010, f5(Z,H,Z,H,Z), ALL, O, O, IDL);
    row(0, r5(O,L,O,L,O), 5'b01010, f5(Z,H,Z,H,Z), ALL, 5'b01000, L, f5(I,I,I,I,3));
    row(0, r5(O,L,O,L,O), 5'b01010, f5(Z,H,Z,T,Z), ALL, 5'b01000, L, f5(I,I,I,I,3));
    row(0, '0, O, '0, ALL, O, O, IDL);
    // Backpressure on S for four cycles mid-packet
    row(0, r5(O,O,S,O,O), 5'b00100, f5(Z,Z,H,Z,Z), ALL, O, O, IDL);
    row(0, r5(O,O,S,O,O), 5'b00100, f5(Z,Z,H,Z,Z), ALL, 5'b00100, S, f5(I,I,I,2,I));
    for (int k = 0; k < 4; k++)
      row(0, r5(O,O,S,O,O), 5'b00100, f5(Z,Z,B,Z,Z), 5'b10111, O, O, f5(I,I,I,2,I));
    row(0, r5(O,O,S,O,O), 5'b00100, f5(Z,Z,B,Z,Z), ALL, 5'b00100, S, f5(I,I,I,2,I));
    row(0, r5(O,O,S,O,O), 5'b00100, f5(Z,Z,T,Z,Z), ALL, 5'b00100, S, f5(I,I,I,2,I));
    row(0, '0, O, '0, ALL, O, O, IDL);
    // Multi-bit route: lowest set bit (E) wins, S stays idle
    row(0, r5(O,O,O,O,5'b01010), 5'b10000, f5(Z,Z,Z,Z,H), ALL, O, O, IDL);
    row(0, r5(O,O,O,O,5'b01010), 5'b10000, f5(Z,Z,Z,Z,H), ALL, 5'b10000, E, f5(I,4,I,I,I));
    row(0, r5(O,O,O,O,5'b01010), 5'b10000, f5(Z,Z,Z,Z,T), ALL, 5'b10000, E, f5(I,4,I,I,I));
    row(0, '0, O, '0, ALL, O, O, IDL);
    // Empty route and headless flit both stall
    row(0, r5(O,E,O,O,O), 5'b00011, f5(H,B,Z,Z,Z), ALL, O, O, IDL);
    row(0, r5(O,E,O,O,O), 5'b00011, f5(H,B,Z,Z,Z), ALL, O, O, IDL);
    // Reset mid-packet, then pointer back at 0 on L (was 4)
    row(0, r5(NN,O,O,O,O), 5'b00001, f5(H,Z,Z,Z,Z), ALL, O, O, IDL);
    row(0, r5(NN,O,O,O,O), 5'b00001, f5(H,Z,Z,Z,Z), ALL, 5'b00001, NN, f5(0,I,I,I,I));
    row(1, r5(NN,O,O,O,O), 5'b00001, f5(B,Z,Z,Z,Z), ALL, O, O, f5(0,I,I,I,I));
    row(0, r5(NN,O,O,O,O), 5'b00001, f5(B,Z,Z,Z,Z), ALL, O, O, IDL);
    row(0, r5(L,O,O,O,L), 5'b10001, f5(H,Z,Z,Z,H), ALL, O, O, IDL);
    row(0, r5(L,O,O,O,L), 5'b10001, f5(H,Z,Z,Z,H), ALL, 5'b00001, L, f5(I,I,I,I,0));
    row(0, r5(L,O,O,O,L), 5'b10001, f5(T,Z,Z,Z,H), ALL, 5'b00001, L, f5(I,I,I,I,0));
    row(0, '0, O, '0, ALL, O, O, IDL);

    foreach (tbl[k]) apply(tbl[k], k);

    // Fairness: inputs 0..3 stream 2-flit packets to S; owners must rotate
    for (int i = 0; i < 4; i++) head[i] = H;
    for (int p = 0; p < 12; p++) ownq.push_back(p % 4);
    cyc = 0;
    while (ownq.size() > 0 && cyc < 80) begin
      drive(1'b0, r5(S,S,S,S,O), 5'b01111, f5(head[0],head[1],head[2],head[3],Z), ALL);
      @(negedge clk);
      rdv = sif.rd_en;
      for (int i = 0; i < 4; i++) begin
        if (rdv[i] && head[i] == T && ownq.size() > 0) begin
          want = ownq.pop_front();
          got  = i;
          cmp("fair_owner", cyc, 25'(got), 25'(want));
          cmp("fair_xbar",  cyc, 25'(sif.xbar_sel[9 +: 3]), 25'(want));
        end
      end
      @(posedge clk);
      for (int i = 0; i < 4; i++)
        if (rdv[i]) head[i] = (head[i] == H) ? T : H;
      #1;
      cyc++;
    end
    if (ownq.size() > 0) begin
      total++; bad++;
      $display("FAIL fair_timeout: %0d packets outstanding, expected 0", ownq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
